// File: rtl/sleep_pkg.sv
// rtl/sleep_pkg.sv - shared sleep-state encoding and parameter range helper
package sleep_pkg;

    typedef enum logic [1:0] {
        ST_AWAKE  = 2'd0,
        ST_DROWSY = 2'd1,
        ST_LIGHT  = 2'd2,
        ST_DEEP   = 2'd3
    } sleep_state_t;

    // A dwell parameter is usable when the counter can still reach value-1.
    function automatic bit cycle_param_ok(input int value, input int cnt_w);
        return (value >= 1) && (value <= (1 << cnt_w));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - clearable up-counter that saturates at all-ones
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clear,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (r_count != {W{1'b1}}) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/sleep_cycle_controller.sv
// rtl/sleep_cycle_controller.sv - AWAKE/DROWSY/LIGHT/DEEP sleep sequencer
// Optional macro SLEEP_FORCE_WAKE_EN adds the force_wake input.
module sleep_cycle_controller
    import sleep_pkg::*;
#(
    parameter int IND_W         = 2,
    parameter int CNT_W         = 4,
    parameter int SLEEP_LEVEL   = 0,
    parameter int STRESS_BLOCK  = 2,
    parameter int MIN_AWAKE     = 4,
    parameter int DROWSY_CYCLES = 2,
    parameter int DEEP_AFTER    = 3,
    parameter int MIN_SLEEP     = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IND_W-1:0] energy_indicator,
    input  logic [IND_W-1:0] stress_indicator,
`ifdef SLEEP_FORCE_WAKE_EN
    input  logic             force_wake,
`endif
    output logic             asleep,
    output logic             deep_sleep,
    output logic             fell_asleep,
    output logic             woke_up,
    output logic             en_inc,
    output logic             en_dec
);

    if (!cycle_param_ok(MIN_AWAKE, CNT_W) || !cycle_param_ok(DROWSY_CYCLES, CNT_W) ||
        !cycle_param_ok(DEEP_AFTER, CNT_W) || !cycle_param_ok(MIN_SLEEP, CNT_W)) begin : g_bad_param
        $error("sleep_cycle_controller: cycle parameter outside 1..2**CNT_W");
    end

    localparam logic [IND_W-1:0] LP_SLEEP_LEVEL  = IND_W'(SLEEP_LEVEL);
    localparam logic [IND_W-1:0] LP_STRESS_BLOCK = IND_W'(STRESS_BLOCK);
    localparam logic [CNT_W-1:0] LP_AWAKE_LAST   = CNT_W'(MIN_AWAKE - 1);
    localparam logic [CNT_W-1:0] LP_DROWSY_LAST  = CNT_W'(DROWSY_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_LIGHT_LAST   = CNT_W'(DEEP_AFTER - 1);
    localparam logic [CNT_W-1:0] LP_DEEP_LAST    = CNT_W'(MIN_SLEEP - 1);

    sleep_state_t     r_state;
    sleep_state_t     w_next;
    logic [CNT_W-1:0] w_cnt;
    logic             w_force;
    logic             w_tired;
    logic             w_stressed;
    logic             r_asleep, r_deep, r_fell, r_woke, r_inc, r_dec;

`ifdef SLEEP_FORCE_WAKE_EN
    assign w_force = force_wake;
`else
    assign w_force = 1'b0;
`endif

    assign w_tired    = (energy_indicator <= LP_SLEEP_LEVEL);
    assign w_stressed = (stress_indicator >= LP_STRESS_BLOCK);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_AWAKE:  if (w_tired && !w_stressed && w_cnt >= LP_AWAKE_LAST) w_next = ST_DROWSY;
            ST_DROWSY: begin
                if (!w_tired || w_stressed)        w_next = ST_AWAKE;
                else if (w_cnt >= LP_DROWSY_LAST)  w_next = ST_LIGHT;
            end
            ST_LIGHT: begin
                if (w_stressed)                    w_next = ST_AWAKE;
                else if (w_cnt >= LP_LIGHT_LAST)   w_next = ST_DEEP;
            end
            ST_DEEP:   if (energy_indicator == {IND_W{1'b1}} && w_cnt >= LP_DEEP_LAST) w_next = ST_AWAKE;
            default:   w_next = ST_AWAKE;
        endcase
        if (w_force) w_next = ST_AWAKE;
    end

    // Dwell counter restarts whenever the state register is about to change.
    sat_counter #(.W(CNT_W)) u_dwell (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_next != r_state),
        .o_count (w_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_AWAKE;
            r_asleep <= 1'b0;
            r_deep   <= 1'b0;
            r_fell   <= 1'b0;
            r_woke   <= 1'b0;
            r_inc    <= 1'b0;
            r_dec    <= 1'b1;
        end else begin
            r_state  <= w_next;
            r_asleep <= (w_next == ST_LIGHT) || (w_next == ST_DEEP);
            r_deep   <= (w_next == ST_DEEP);
            r_inc    <= (w_next == ST_LIGHT) || (w_next == ST_DEEP);
            r_dec    <= (w_next == ST_AWAKE);
            r_fell   <= (r_state == ST_DROWSY) && (w_next == ST_LIGHT);
            r_woke   <= ((r_state == ST_LIGHT) || (r_state == ST_DEEP)) && (w_next == ST_AWAKE);
        end
    end

    assign asleep      = r_asleep;
    assign deep_sleep  = r_deep;
    assign fell_asleep = r_fell;
    assign woke_up     = r_woke;
    assign en_inc      = r_inc;
    assign en_dec      = r_dec;

endmodule

// File: doc/sleep_cycle_controller.md
SLEEP_CYCLE_CONTROLLER -- requirements
Module: sleep_cycle_controller

Interface
REQ-001 Parameter IND_W, default 2: width of both indicator inputs.
REQ-002 Parameter CNT_W, default 4: width of the shared dwell counter.
REQ-003 Parameter SLEEP_LEVEL, default 0: energy at or below which drowsiness may start.
REQ-004 Parameter STRESS_BLOCK, default 2: stress at or above which sleep is blocked or broken.
REQ-005 Parameter MIN_AWAKE, default 4: minimum cycles in AWAKE before DROWSY.
REQ-006 Parameter DROWSY_CYCLES, default 2: cycles in DROWSY before LIGHT.
REQ-007 Parameter DEEP_AFTER, default 3: minimum cycles in LIGHT before DEEP.
REQ-008 Parameter MIN_SLEEP, default 6: minimum cycles in DEEP before waking.
REQ-009 clk  in  1  single clock; all state updates on rising edge.
REQ-010 rst_n  in  1  reset; synchronous, active-low.
REQ-011 energy_indicator  in  IND_W  energy level, 0 = exhausted, all-ones = full.
REQ-012 stress_indicator  in  IND_W  stress level, 0 = calm.
REQ-013 asleep  out  1  high in LIGHT or DEEP.
REQ-014 deep_sleep  out  1  high in DEEP only.
REQ-015 fell_asleep  out  1  one-cycle pulse, first LIGHT cycle entered from DROWSY.
REQ-016 woke_up  out  1  one-cycle pulse, first AWAKE cycle entered from LIGHT or DEEP.
REQ-017 en_inc  out  1  energy-recharge enable, high in LIGHT and DEEP.
REQ-018 en_dec  out  1  energy-drain enable, high in AWAKE only.

Function
REQ-019 States AWAKE, DROWSY, LIGHT, DEEP; asleep, deep_sleep, en_inc and en_dec are Moore-decoded from the state register; fell_asleep and woke_up are registered flags.
REQ-020 Counter cnt clears to 0 on every state change, else increments each cycle, saturating at 2^CNT_W-1.
REQ-021 AWAKE -> DROWSY when energy <= SLEEP_LEVEL, stress < STRESS_BLOCK and cnt >= MIN_AWAKE-1.
REQ-022 DROWSY -> AWAKE when energy > SLEEP_LEVEL or stress >= STRESS_BLOCK (priority); else DROWSY -> LIGHT when cnt >= DROWSY_CYCLES-1.
REQ-023 LIGHT -> AWAKE when stress >= STRESS_BLOCK (priority); else LIGHT -> DEEP when cnt >= DEEP_AFTER-1.
REQ-024 DEEP ignores stress; DEEP -> AWAKE only when energy equals all-ones and cnt >= MIN_SLEEP-1.
REQ-025 No other transitions; each state otherwise holds.
REQ-026 Indicator comparisons are unsigned at IND_W bits.
REQ-027 All cycle parameters are >= 1 and <= 2^CNT_W; violation is a compile-time error.

Reset
REQ-028 While rst_n is low at a rising edge: state = AWAKE, cnt = 0, flags cleared; outputs asleep 0, deep_sleep 0, fell_asleep 0, woke_up 0, en_inc 0, en_dec 1.
REQ-029 Reset in any state, including mid-DEEP, takes effect at the next edge and emits no woke_up pulse.

Configuration
REQ-030 Macro SLEEP_FORCE_WAKE_EN defined: adds input force_wake (1 bit); high at an edge forces any state to AWAKE, above all other transitions, with woke_up pulsed if leaving LIGHT or DEEP.
REQ-031 Macro SLEEP_FORCE_WAKE_EN undefined: the port is absent and behaviour is identical to force_wake tied 0.

Structure
REQ-032 State encoding (2-bit) and state names are defined in shared package sleep_pkg, reused by the top-level mood logic.
REQ-033 The saturating clear/increment counter is sub-module sat_counter (parameter W).

Verification (defaults; cycle 0 = first edge after rst_n rises)
REQ-034 Energy 0 and stress 0 held: AWAKE c0-c3 (en_dec 1), DROWSY c4-c5, LIGHT c6 with fell_asleep 1 for c6 only, DEEP from c9 with deep_sleep 1.
REQ-035 Stress driven to 2 in DROWSY: AWAKE next cycle, woke_up 0, fell_asleep never pulses.
REQ-036 Stress driven to 3 in LIGHT: AWAKE next cycle, woke_up 1 for one cycle, asleep 0, en_dec 1.
REQ-037 In DEEP with stress 3: stays DEEP. Energy 3 at DEEP cnt 2: stays DEEP. Energy 3 held: AWAKE after DEEP cnt 5, woke_up pulses once.
REQ-038 rst_n low for one edge mid-DEEP: all outputs at reset values next cycle, woke_up 0, restart timing matches REQ-034.
REQ-039 With SLEEP_FORCE_WAKE_EN, force_wake 1 in DEEP at cnt 1: AWAKE next cycle, woke_up 1. Without the macro, build has no force_wake port.
